// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer and its bit-rate prescaler.
package bit_serializer_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned DIV_DEFAULT   = 1;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-rate prescaler: while enabled, pulses tick on the last clock of every DIV-clock bit period.
module bit_tick_gen
    import bit_serializer_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned   CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Held at zero while disabled so every new word starts on a full bit period.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a one-deep holding register, so a
// pending word reloads on the last bit's final clock and consecutive words have no gap.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DIV   = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_shift;
    logic             r_hold_full;
    logic             r_done;
    logic [BW-1:0]    r_bit_cnt;

    logic w_shifting;
    logic w_tick;
    logic w_accept;
    logic w_word_end;
    logic w_load;

    assign w_shifting = (r_state == StShift);

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_shifting),
        .tick (w_tick)
    );

    assign w_accept   = in_valid && !r_hold_full;
    assign w_word_end = w_shifting && w_tick && (r_bit_cnt == LAST_BIT);
    assign w_load     = r_hold_full && (!w_shifting || w_word_end);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_word_end;

            // Accept wins over drain so a same-edge refill leaves hold full.
            if (w_accept) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (r_hold_full) begin
                        r_state   <= StShift;
                        r_shift   <= r_hold;
                        r_bit_cnt <= '0;
                    end
                end
                StShift: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            if (r_hold_full) begin
                                r_shift <= r_hold;
                            end else begin
                                r_state <= StIdle;
                                r_shift <= '0;
                            end
                        end else begin
                            r_shift   <= r_shift << 1;
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready   = !r_hold_full;
    assign sout       = w_shifting && r_shift[WIDTH-1];
    assign sout_valid = w_shifting;
    assign busy       = w_shifting || r_hold_full;
    assign done       = r_done;

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: bits per word.
REQ-002 Parameter DIV, default 1: clocks per serial bit (DIV >= 1).
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  WIDTH  parallel word to transmit.
REQ-006 in_valid  input  1  in_data holds a word to send.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  serial bit stream, MSB first; drives the downstream 1101 sequence detector input i.
REQ-009 sout_valid  output  1  sout carries a data bit (not idle filler).
REQ-010 busy  output  1  a word is shifting or a word is held pending.
REQ-011 done  output  1  one-cycle pulse after the last bit of a word ends.

Function
REQ-012 Handshake SHALL be: a word is accepted on any posedge where in_valid=1 and in_ready=1; in_data is captured into a one-deep holding register.
REQ-013 in_ready SHALL equal NOT hold_full; it is derived from registers only, with no combinational path from in_valid.
REQ-014 The FSM SHALL have two states: IDLE and SHIFT.
REQ-015 Transition IDLE->SHIFT SHALL occur on the posedge where hold_full=1; that edge moves hold into the shift register and clears hold_full.
REQ-016 Latency: for a word accepted at edge k while IDLE, its MSB SHALL appear on sout after edge k+1.
REQ-017 In SHIFT, each bit SHALL be held for exactly DIV clocks; a prescaler counts 0..DIV-1 and the bit advances when it wraps.
REQ-018 The bit counter SHALL count 0..WIDTH-1; after the last bit's final clock, the FSM SHALL reload from hold if hold_full=1 (stays in SHIFT, no gap cycle), else go to IDLE.
REQ-019 If a new word is accepted on the same edge that hold is drained, hold_full SHALL end at 1 and hold SHALL contain the new word.
REQ-020 In IDLE, sout SHALL be 0 and sout_valid 0; in SHIFT, sout_valid SHALL be 1.
REQ-021 done SHALL be 1 for exactly one cycle following each completed word, including during back-to-back transfers.
REQ-022 busy SHALL be (state==SHIFT) OR hold_full.
REQ-023 in_valid while in_ready=0 SHALL be ignored; the word is not captured and in_data may change freely.

Reset
REQ-024 When rst=0 at a posedge, the following SHALL apply: state=IDLE, hold_full=0, shift register=0, bit and prescaler counters=0.
REQ-025 Outputs while in reset SHALL be: sout=0, sout_valid=0, done=0, busy=0, in_ready=1.
REQ-026 Reset mid-word SHALL abort the word: partial bits are discarded, the pending word is dropped, and no done pulse is produced.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, SHIFT) and the WIDTH and DIV defaults.
REQ-028 The prescaler SHALL be a sub-module bit_tick_gen (inputs clk, rst, en; output tick every DIV clocks).
REQ-029 Counter widths SHALL be clog2(WIDTH) and clog2(DIV), each at least 1 bit.

Verification
REQ-030 DIV=1, send 8'hD0 at edge k -> sout = 1,1,0,1,0,0,0,0 after edges k+1..k+8; done=1 after edge k+9; the downstream detector sees 1101.
REQ-031 Back-to-back 8'hD0 then 8'hA5 with in_valid held -> 16 contiguous sout_valid cycles, no gap, two done pulses 8 cycles apart.
REQ-032 DIV=3, send 8'h81 -> sout=1 for 3 cycles, 0 for 18 cycles, then 1 for 3 cycles; done 24 cycles after the first bit.
REQ-033 With hold full and shifting, assert in_valid with 8'hFF -> in_ready=0 and the word is not captured; it is accepted on the cycle in_ready returns to 1.
REQ-034 rst=0 at the 4th bit of 8'hD0 -> after that edge sout=0, busy=0, in_ready=1; no done pulse; the next word transmits correctly.
